// File: rtl/oai_lane_checker.sv
// Built-in self-test sequencer for an inverter/OAI222 lane array: drives LFSR
// vectors, waits for the array to settle, checks every 4-bit lane against its model.

module oai_lane_cmp (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] c,
  output logic       mism
);
  logic [3:0] e;

  always_comb begin
    e[0] = ~a[0];
    e[1] = ~b[0];
    e[2] = ~b[1];
    e[3] = ~((a[1] | a[2]) & (b[1] | b[2]) & (a[3] | b[3]));
  end

  assign mism = (c != e);
endmodule

module oai_lane_checker #(
  parameter int SETTLE = 1,
  parameter int LANES  = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] num_vectors,
  input  logic [31:0] seed,
  output logic [40:0] drv_a,
  output logic [40:0] drv_b,
  input  logic [40:0] dut_c,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] first_err_vec,
  output logic [3:0]  first_err_lane,
  output logic        first_err_valid
);
  localparam int W = 4 * LANES;
  localparam logic [31:0] MASK = 32'h8020_0003;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    GEN   = 5'b00010,
    HOLD  = 5'b00100,
    CHECK = 5'b01000,
    DONE  = 5'b10000
  } state_t;

  state_t state_q, state_d;

  logic [31:0] lfsr_q, lfsr_nx;
  logic [31:0] s0_q;
  logic [17:0] s1_q;
  logic [15:0] idx_q, idx_nx, nv_q;
  logic [3:0]  cnt_q;

  logic in_idle, in_gen, in_hold, in_check, in_done;
  logic accept, gen_last, hold_last, more;

  assign in_idle  = state_q[0];
  assign in_gen   = state_q[1];
  assign in_hold  = state_q[2];
  assign in_check = state_q[3];
  assign in_done  = state_q[4];

  assign accept    = start & (in_idle | in_done);
  assign gen_last  = in_gen & (cnt_q == 4'd2);
  assign hold_last = in_hold & (cnt_q == 4'(SETTLE - 1));
  assign idx_nx    = idx_q + 16'd1;
  assign more      = idx_nx < nv_q;
  assign lfsr_nx   = lfsr_q[0] ? ((lfsr_q >> 1) ^ MASK) : (lfsr_q >> 1);

  // Lane array: only the low 4*LANES bits of the response take part in the check.
  logic [LANES-1:0][3:0] a_l, b_l, c_l;
  logic [LANES-1:0]      lane_mism;
  logic                  unused_hi;

  assign a_l       = drv_a[W-1:0];
  assign b_l       = drv_b[W-1:0];
  assign c_l       = dut_c[W-1:0];
  assign unused_hi = ^{dut_c[40:W], drv_a[40:W], drv_b[40:W]};

  oai_lane_cmp u_lane [LANES-1:0] (
    .a    (a_l),
    .b    (b_l),
    .c    (c_l),
    .mism (lane_mism)
  );

  logic [3:0] low_lane;
  always_comb begin
    low_lane = 4'd0;
    for (int k = LANES - 1; k >= 0; k--)
      if (lane_mism[k]) low_lane = 4'(k);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (in_idle || in_done) begin
      if (start) state_d = (num_vectors == 16'd0) ? DONE : GEN;
    end else if (in_gen) begin
      if (gen_last) state_d = HOLD;
    end else if (in_hold) begin
      if (hold_last) state_d = CHECK;
    end else if (in_check) begin
      state_d = more ? GEN : DONE;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q          <= 32'd1;
      s0_q            <= '0;
      s1_q            <= '0;
      idx_q           <= '0;
      nv_q            <= '0;
      cnt_q           <= '0;
      drv_a           <= '0;
      drv_b           <= '0;
      err_count       <= '0;
      first_err_vec   <= '0;
      first_err_lane  <= '0;
      first_err_valid <= 1'b0;
    end else begin
      if (accept) begin
        lfsr_q          <= (seed == 32'd0) ? 32'd1 : seed;
        idx_q           <= '0;
        nv_q            <= num_vectors;
        cnt_q           <= '0;
        err_count       <= '0;
        first_err_vec   <= '0;
        first_err_lane  <= '0;
        first_err_valid <= 1'b0;
      end
      if (in_gen) begin
        lfsr_q <= lfsr_nx;
        cnt_q  <= gen_last ? 4'd0 : cnt_q + 4'd1;
        if (cnt_q == 4'd0) s0_q <= lfsr_nx;
        if (cnt_q == 4'd1) s1_q <= lfsr_nx[17:0];
        // Third step is consumed straight from the LFSR output as s2.
        if (gen_last) begin
          drv_a <= {s1_q[8:0], s0_q};
          drv_b <= {s1_q[17:9], lfsr_nx};
        end
      end
      if (in_hold) cnt_q <= hold_last ? 4'd0 : cnt_q + 4'd1;
      if (in_check) begin
        idx_q <= idx_nx;
        if (|lane_mism) begin
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          if (!first_err_valid) begin
            first_err_vec   <= idx_q;
            first_err_lane  <= low_lane;
            first_err_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign busy = in_gen | in_hold | in_check;
  assign done = in_done;
  assign pass = in_done & (err_count == 16'd0);
endmodule

// File: tb/tb_oai_lane_checker.sv
// Directed bench for oai_lane_checker: a behavioural lane array with optional
// stuck-at faults answers the checker's drive vectors.

module tb_oai_lane_checker;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] num_vectors;
  logic [31:0] seed;
  logic [40:0] drv_a, drv_b, dut_c;
  logic        busy, done, pass;
  logic [15:0] err_count, first_err_vec;
  logic [3:0]  first_err_lane;
  logic        first_err_valid;

  int tests = 0;
  int fails = 0;
  int fault_mode = 0;

  oai_lane_checker #(.SETTLE(1), .LANES(9)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors), .seed(seed),
    .drv_a(drv_a), .drv_b(drv_b), .dut_c(dut_c), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_vec(first_err_vec),
    .first_err_lane(first_err_lane), .first_err_valid(first_err_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [40:0] array_c(input logic [40:0] a, input logic [40:0] b, input int fm);
    logic [40:0] c;
    c = '0;
    for (int k = 0; k < 9; k++) begin
      c[4*k]   = ~a[4*k];
      c[4*k+1] = ~b[4*k];
      c[4*k+2] = ~b[4*k+1];
      c[4*k+3] = ~((a[4*k+1] | a[4*k+2]) & (b[4*k+1] | b[4*k+2]) & (a[4*k+3] | b[4*k+3]));
    end
    if (fm == 1) c[7] = 1'b0;
    if (fm == 2) c[38] = 1'b1;
    return c;
  endfunction

  assign dut_c = array_c(drv_a, drv_b, fault_mode);

  function automatic logic [31:0] step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  task automatic model_vec(input logic [31:0] sd, input int n, output logic [40:0] a, output logic [40:0] b);
    logic [31:0] l, s0, s1, s2;
    l = (sd == 32'd0) ? 32'd1 : sd;
    a = '0; b = '0;
    for (int v = 0; v <= n; v++) begin
      s0 = step(l); s1 = step(s0); s2 = step(s1); l = s2;
      a = {s1[8:0], s0};
      b = {s1[17:9], s2};
    end
  endtask

  task automatic c7_expect(input logic [31:0] sd, input int n, output int cnt, output int first);
    logic [40:0] a, b;
    cnt = 0; first = -1;
    for (int v = 0; v < n; v++) begin
      model_vec(sd, v, a, b);
      if (!((a[5] | a[6]) & (b[5] | b[6]) & (a[7] | b[7]))) begin
        cnt++;
        if (first < 0) first = v;
      end
    end
  endtask

  task automatic run(input logic [15:0] n, input logic [31:0] sd, output int lat);
    @(negedge clk);
    start = 1'b1; num_vectors = n; seed = sd;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; num_vectors = '0; seed = '0;
    #1;
    tests++;
    if ({busy, done, pass, first_err_valid, first_err_lane, err_count, first_err_vec, drv_a, drv_b} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b done=%b pass=%b err=%h drv_a=%h drv_b=%h, want all 0",
               busy, done, pass, err_count, drv_a, drv_b);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero_vectors;
    int lat;
    run(16'd0, 32'h1234, lat);
    tests++;
    if (lat !== 0 || done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_vectors: got lat=%0d done=%b pass=%b busy=%b, want lat=0 done=1 pass=1 busy=0",
               lat, done, pass, busy);
    end
  endtask

  task automatic test_seed_zero;
    int lat;
    logic [40:0] ea, eb;
    run(16'd1, 32'd0, lat);
    tests++;
    if (lat !== 5 || drv_a !== 41'h0_0280200003 || drv_b !== 41'h0_0060180001) begin
      fails++;
      $display("FAIL seed0_vec0: got lat=%0d a=%h b=%h, want lat=5 a=00280200003 b=00060180001", lat, drv_a, drv_b);
    end
    run(16'd1, 32'd1, lat);
    tests++;
    if (drv_a !== 41'h0_0280200003 || drv_b !== 41'h0_0060180001) begin
      fails++;
      $display("FAIL seed1_vec0: got a=%h b=%h, want a=00280200003 b=00060180001", drv_a, drv_b);
    end
    run(16'd3, 32'd0, lat);
    model_vec(32'd1, 2, ea, eb);
    tests++;
    if (lat !== 15 || drv_a !== ea || drv_b !== eb) begin
      fails++;
      $display("FAIL seed0_vec2: got lat=%0d a=%h b=%h, want lat=15 a=%h b=%h", lat, drv_a, drv_b, ea, eb);
    end
  endtask

  task automatic test_golden;
    int lat;
    logic [40:0] ea, eb;
    fault_mode = 0;
    run(16'd100, 32'h0000_ACE1, lat);
    model_vec(32'h0000_ACE1, 99, ea, eb);
    tests++;
    if (lat !== 500) begin
      fails++;
      $display("FAIL golden_latency: got %0d want 500", lat);
    end
    tests++;
    if (pass !== 1'b1 || err_count !== 16'd0 || first_err_valid !== 1'b0 || first_err_vec !== 16'd0) begin
      fails++;
      $display("FAIL golden_result: got pass=%b err=%0d fev=%b vec=%0d, want pass=1 err=0 fev=0 vec=0",
               pass, err_count, first_err_valid, first_err_vec);
    end
    tests++;
    if (drv_a !== ea || drv_b !== eb) begin
      fails++;
      $display("FAIL golden_last_vec: got a=%h b=%h want a=%h b=%h", drv_a, drv_b, ea, eb);
    end
  endtask

  task automatic test_stuck_c7;
    int lat, cnt, first;
    c7_expect(32'h0000_ACE1, 50, cnt, first);
    fault_mode = 1;
    run(16'd50, 32'h0000_ACE1, lat);
    tests++;
    if (lat !== 250 || pass !== 1'b0 || err_count !== 16'(cnt)) begin
      fails++;
      $display("FAIL c7_count: got lat=%0d pass=%b err=%0d, want lat=250 pass=0 err=%0d", lat, pass, err_count, cnt);
    end
    tests++;
    if (first_err_valid !== 1'b1 || first_err_lane !== 4'd1 || first_err_vec !== 16'(first)) begin
      fails++;
      $display("FAIL c7_first: got valid=%b lane=%0d vec=%0d, want valid=1 lane=1 vec=%0d",
               first_err_valid, first_err_lane, first_err_vec, first);
    end
    repeat (4) @(negedge clk);
    tests++;
    if (done !== 1'b1 || err_count !== 16'(cnt) || first_err_vec !== 16'(first) || first_err_lane !== 4'd1) begin
      fails++;
      $display("FAIL c7_done_hold: got done=%b err=%0d vec=%0d lane=%0d, want done=1 err=%0d vec=%0d lane=1",
               done, err_count, first_err_vec, first_err_lane, cnt, first);
    end
    fault_mode = 0;
  endtask

  task automatic test_ignored_bits;
    int lat;
    fault_mode = 2;
    run(16'd20, 32'h1234_5678, lat);
    tests++;
    if (lat !== 100 || pass !== 1'b1 || err_count !== 16'd0) begin
      fails++;
      $display("FAIL c38_ignored: got lat=%0d pass=%b err=%0d, want lat=100 pass=1 err=0", lat, pass, err_count);
    end
    fault_mode = 0;
  endtask

  task automatic test_start_in_hold;
    int lat;
    logic [40:0] ea, eb;
    @(negedge clk);
    start = 1'b1; num_vectors = 16'd2; seed = 32'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL hold_busy: got %b want 1", busy);
    end
    start = 1'b1; num_vectors = 16'd40; seed = 32'h0000_ACE1;
    @(negedge clk);
    start = 1'b0;
    lat = 4;
    while (!done && lat < 20000) begin
      @(negedge clk);
      lat++;
    end
    model_vec(32'd1, 1, ea, eb);
    tests++;
    if (lat !== 10 || pass !== 1'b1 || drv_a !== ea || drv_b !== eb) begin
      fails++;
      $display("FAIL start_in_hold: got lat=%0d pass=%b a=%h b=%h, want lat=10 pass=1 a=%h b=%h",
               lat, pass, drv_a, drv_b, ea, eb);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat, cnt, first;
    fault_mode = 1;
    @(negedge clk);
    start = 1'b1; num_vectors = 16'd50; seed = 32'h0000_ACE1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    tests++;
    if (busy !== 1'b1 || err_count === 16'd0) begin
      fails++;
      $display("FAIL midrun_state: got busy=%b err=%0d, want busy=1 err>0", busy, err_count);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, pass, first_err_valid, first_err_lane, err_count, first_err_vec, drv_a, drv_b} !== '0) begin
      fails++;
      $display("FAIL async_reset: got busy=%b done=%b err=%h vec=%h drv_a=%h drv_b=%h, want all 0",
               busy, done, err_count, first_err_vec, drv_a, drv_b);
    end
    @(negedge clk);
    rst = 1'b0;
    c7_expect(32'h0000_ACE1, 10, cnt, first);
    run(16'd10, 32'h0000_ACE1, lat);
    tests++;
    if (lat !== 50 || err_count !== 16'(cnt) || first_err_vec !== 16'(first) || first_err_lane !== 4'd1) begin
      fails++;
      $display("FAIL fresh_after_reset: got lat=%0d err=%0d vec=%0d lane=%0d, want lat=50 err=%0d vec=%0d lane=1",
               lat, err_count, first_err_vec, first_err_lane, cnt, first);
    end
    fault_mode = 0;
  endtask

  initial begin
    test_reset;
    test_zero_vectors;
    test_seed_zero;
    test_golden;
    test_stuck_c7;
    test_ignored_bits;
    test_start_in_hold;
    test_reset_mid_run;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/oai_lane_checker.md
OAI_LANE_CHECKER -- requirements
Module: oai_lane_checker

Interface
REQ-001 Parameter SETTLE, default 1: hold cycles between driving a vector and sampling dut_c (legal range 1..15).
REQ-002 Parameter LANES, default 9: number of 4-bit lanes checked, covering dut_c[4*LANES-1:0]; dut_c[40:36] is never compared.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle run request; honoured only in IDLE or DONE.
REQ-006 num_vectors  input  16  number of vectors in the run; sampled on an accepted start.
REQ-007 seed  input  32  LFSR seed; sampled on an accepted start.
REQ-008 drv_a  output  41  A operand driven to the inverter/OAI222 lane array under test.
REQ-009 drv_b  output  41  B operand (inout side of the array) driven by this block.
REQ-010 dut_c  input  41  C response from the array under test.
REQ-011 busy  output  1  high from the cycle after start until DONE is entered.
REQ-012 done  output  1  high while in DONE.
REQ-013 pass  output  1  high in DONE when err_count==0.
REQ-014 err_count  output  16  number of mismatching vectors; saturates at 0xFFFF.
REQ-015 first_err_vec  output  16  vector index (0-based) of the first mismatch.
REQ-016 first_err_lane  output  4  lowest failing lane index within that first mismatch.
REQ-017 first_err_valid  output  1  high once a first mismatch has been captured.

Function
REQ-018 FSM states SHALL be IDLE, GEN, HOLD, CHECK and DONE, with single-hot decode.
REQ-019 IDLE/DONE + start SHALL clear the counters and first_err_* and load lfsr=seed, with seed 0 replaced by 0x00000001.
- If num_vectors==0, the FSM goes to DONE on the next cycle.
- Otherwise it goes to GEN.
REQ-020 The LFSR SHALL be a 32-bit Galois register, mask 0x80200003, shifted right once per GEN cycle.
REQ-021 GEN SHALL last exactly 3 cycles, capturing the post-step states s0, s1 and s2 in order.
- drv_a = {s1[8:0], s0}.
- drv_b = {s1[17:9], s2}.
- Both outputs update only on the last GEN cycle.
REQ-022 HOLD SHALL last exactly SETTLE cycles with drv_a and drv_b stable.
REQ-023 CHECK SHALL last 1 cycle and compare dut_c against the expected value for every lane k, with b=4k:
- e[b] = ~A[b]
- e[b+1] = ~B[b]
- e[b+2] = ~B[b+1]
- e[b+3] = ~((A[b+1]|A[b+2]) & (B[b+1]|B[b+2]) & (A[b+3]|B[b+3]))
REQ-024 Any mismatched lane in a vector SHALL increment err_count by exactly 1, saturating at 0xFFFF.
REQ-025 On the first failing vector only, CHECK SHALL capture first_err_vec, first_err_lane (lowest failing k) and first_err_valid=1; later mismatches SHALL NOT overwrite them.
REQ-026 After CHECK, the FSM SHALL increment the vector index and go to GEN if index < num_vectors, else to DONE.
- Per-vector latency is 4+SETTLE cycles.
- A full run takes num_vectors*(4+SETTLE) cycles from the start edge to done.
REQ-027 start asserted in GEN, HOLD or CHECK SHALL be ignored with no effect on state.
REQ-028 DONE SHALL hold done, pass, err_count and first_err_* stable until an accepted start or rst.
REQ-029 drv_a and drv_b SHALL retain their last values in IDLE and DONE.

Reset
REQ-030 rst SHALL force the following immediately, regardless of clk:
- state=IDLE, lfsr=1, index=0.
- drv_a=0, drv_b=0.
- busy=0, done=0, pass=0.
- err_count=0, first_err_vec=0, first_err_lane=0, first_err_valid=0.
REQ-031 rst asserted mid-run SHALL abandon the run with no partial result retained; the first start after deassertion SHALL begin a fresh run.

Verification
REQ-032 Reset: assert rst mid-cycle without a clock edge -> every output reads 0 immediately.
REQ-033 Golden array model, num_vectors=100, seed=0xACE1, SETTLE=1 -> done exactly 500 cycles after start; pass=1, err_count=0, first_err_valid=0.
REQ-034 Model with C[7] stuck-at-0, num_vectors=50 -> first_err_lane=1, first_err_vec equals the first vector whose expected C[7]=1, and err_count equals the number of such vectors.
REQ-035 Model with C[38] stuck-at-1 -> pass=1, because bits 40:36 are ignored.
REQ-036 num_vectors=0 -> done=1 one cycle after start with pass=1; seed=0 -> identical drv_a/drv_b sequence to seed=1.
REQ-037 Boundary run: start pulsed in HOLD -> no restart; rst mid-run followed by start -> fresh run with err_count restarting from 0.
